// File: rtl/key_event_decoder_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : key_event_decoder_if
// Description : Key pulse inputs and user-level event outputs of the decoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface key_event_decoder_if;
    logic key_press;
    logic key_release;
    logic short_press;
    logic double_click;
    logic long_press;
    logic repeat_tick;
    logic busy;

    // master: debouncer / player side; slave: the decoder itself
    modport master (
        output key_press,
        output key_release,
        input  short_press,
        input  double_click,
        input  long_press,
        input  repeat_tick,
        input  busy
    );

    modport slave (
        input  key_press,
        input  key_release,
        output short_press,
        output double_click,
        output long_press,
        output repeat_tick,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/key_event_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : key_event_decoder
// Description : Turns debounced press/release pulses into short, double,
//               long and auto-repeat key events.
// Revision    : 1.0 - initial release
// ============================================================================
module key_event_decoder #(
    parameter int FREQ      = 50,
    parameter int LONG_MS   = 1000,
    parameter int DCLICK_MS = 250,
    parameter int REPEAT_MS = 200,
    parameter int N         = 32
) (
    input  wire logic           clk,
    input  wire logic           rst,
    key_event_decoder_if.slave  bus
);

    // Timeout compare values are the cycle limits minus one
    localparam logic [N-1:0] c_T_LONG = N'(LONG_MS   * 1000 * FREQ - 1);
    localparam logic [N-1:0] c_T_DC   = N'(DCLICK_MS * 1000 * FREQ - 1);
    localparam logic [N-1:0] c_T_REP  = N'(REPEAT_MS * 1000 * FREQ - 1);
    localparam logic [N-1:0] c_ONE    = N'(1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_PRESS1 = 3'd1;
    localparam logic [2:0] c_WAIT2  = 3'd2;
    localparam logic [2:0] c_PRESS2 = 3'd3;
    localparam logic [2:0] c_LONG   = 3'd4;

    logic [2:0]   r_state;
    logic [2:0]   w_state_nxt;
    logic [N-1:0] r_cnt;
    logic [N-1:0] w_cnt_nxt;
    logic [N-1:0] w_cnt_inc;
    logic         w_press;
    logic         w_release;
    logic         w_short;
    logic         w_double;
    logic         w_long;
    logic         w_repeat;
    logic         r_short;
    logic         r_double;
    logic         r_long;
    logic         r_repeat;
    logic         r_busy;

    // Simultaneous press and release cancel each other out
    assign w_press   = bus.key_press & ~bus.key_release;
    assign w_release = bus.key_release & ~bus.key_press;

    // Saturate so a long-held second press cannot wrap the timer
    assign w_cnt_inc = (r_cnt == {N{1'b1}}) ? r_cnt : r_cnt + c_ONE;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = (r_state == c_IDLE) ? '0 : w_cnt_inc;
        w_short     = 1'b0;
        w_double    = 1'b0;
        w_long      = 1'b0;
        w_repeat    = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_press) begin
                    w_state_nxt = c_PRESS1;
                end
            end
            c_PRESS1: begin
                if (w_release) begin
                    w_state_nxt = c_WAIT2;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_T_LONG) begin
                    w_long      = 1'b1;
                    w_state_nxt = c_LONG;
                    w_cnt_nxt   = '0;
                end
            end
            c_WAIT2: begin
                if (w_press) begin
                    w_state_nxt = c_PRESS2;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_T_DC) begin
                    w_short     = 1'b1;
                    w_state_nxt = c_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            c_PRESS2: begin
                if (w_release) begin
                    w_double    = 1'b1;
                    w_state_nxt = c_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            c_LONG: begin
                if (w_release) begin
                    w_state_nxt = c_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_T_REP) begin
                    w_repeat    = 1'b1;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_cnt    <= '0;
            r_short  <= 1'b0;
            r_double <= 1'b0;
            r_long   <= 1'b0;
            r_repeat <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_short  <= w_short;
            r_double <= w_double;
            r_long   <= w_long;
            r_repeat <= w_repeat;
            r_busy   <= (w_state_nxt != c_IDLE);
        end
    end

    assign bus.short_press  = r_short;
    assign bus.double_click = r_double;
    assign bus.long_press   = r_long;
    assign bus.repeat_tick  = r_repeat;
    assign bus.busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_key_event_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_key_event_decoder
// Description : Directed and random key sequences against a deadline model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_event_decoder;

    localparam int FREQ      = 1;
    localparam int LONG_MS   = 5;
    localparam int DCLICK_MS = 2;
    localparam int REPEAT_MS = 1;
    localparam int L_LONG    = LONG_MS * 1000 * FREQ;
    localparam int L_DC      = DCLICK_MS * 1000 * FREQ;
    localparam int L_REP     = REPEAT_MS * 1000 * FREQ;

    // model phases: what the user is doing, each with an absolute deadline
    localparam int M_IDLE  = 0;
    localparam int M_HOLD1 = 1;
    localparam int M_GAP   = 2;
    localparam int M_HOLD2 = 3;
    localparam int M_REP   = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    key_event_decoder_if bus();

    key_event_decoder #(
        .FREQ      (FREQ),
        .LONG_MS   (LONG_MS),
        .DCLICK_MS (DCLICK_MS),
        .REPEAT_MS (REPEAT_MS),
        .N         (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    int   mode     = M_IDLE;
    int   deadline = 0;
    logic e_short, e_double, e_long, e_repeat, e_busy;
    int   n_short, n_double, n_long, n_repeat;
    int   t_short, t_double, t_long, t_repeat;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected outputs right after the edge that sampled p/r/rs at index cyc
    task automatic model(input logic p, input logic r, input logic rs);
        logic ev_p;
        logic ev_r;
        ev_p = p & ~r;
        ev_r = r & ~p;
        e_short = 0; e_double = 0; e_long = 0; e_repeat = 0;
        if (rs) begin
            mode = M_IDLE;
        end else begin
            case (mode)
                M_IDLE:  if (ev_p) begin mode = M_HOLD1; deadline = cyc + L_LONG; end
                M_HOLD1: if (ev_r) begin mode = M_GAP; deadline = cyc + L_DC; end
                         else if (cyc == deadline) begin
                             e_long = 1; mode = M_REP; deadline = cyc + L_REP;
                         end
                M_GAP:   if (ev_p) mode = M_HOLD2;
                         else if (cyc == deadline) begin e_short = 1; mode = M_IDLE; end
                M_HOLD2: if (ev_r) begin e_double = 1; mode = M_IDLE; end
                M_REP:   if (ev_r) mode = M_IDLE;
                         else if (cyc == deadline) begin
                             e_repeat = 1; deadline = cyc + L_REP;
                         end
                default: mode = M_IDLE;
            endcase
        end
        e_busy = (mode != M_IDLE);
    endtask

    task automatic step(input logic p, input logic r, input logic rs);
        bus.key_press   = p;
        bus.key_release = r;
        rst             = rs;
        @(posedge clk);
        cyc++;
        model(p, r, rs);
        #1;
        check("short_press",  bus.short_press,  e_short);
        check("double_click", bus.double_click, e_double);
        check("long_press",   bus.long_press,   e_long);
        check("repeat_tick",  bus.repeat_tick,  e_repeat);
        check("busy",         bus.busy,         e_busy);
        if (bus.short_press  === 1'b1) begin n_short++;  t_short  = cyc; end
        if (bus.double_click === 1'b1) begin n_double++; t_double = cyc; end
        if (bus.long_press   === 1'b1) begin n_long++;   t_long   = cyc; end
        if (bus.repeat_tick  === 1'b1) begin n_repeat++; t_repeat = cyc; end
        bus.key_press   = 1'b0;
        bus.key_release = 1'b0;
        rst             = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic clear_counts();
        n_short = 0; n_double = 0; n_long = 0; n_repeat = 0;
        t_short = 0; t_double = 0; t_long = 0; t_repeat = 0;
    endtask

    function automatic int pick_gap();
        case ($urandom_range(0, 4))
            0:       return $urandom_range(1, 20);
            1:       return $urandom_range(L_DC - 2, L_DC + 1);
            2:       return $urandom_range(L_LONG - 2, L_LONG + 1);
            3:       return $urandom_range(1, 600);
            default: return $urandom_range(L_REP - 1, L_REP + 1);
        endcase
    endfunction

    int t0;
    int rel;

    initial begin
        bus.key_press   = 1'b0;
        bus.key_release = 1'b0;
        clear_counts();
        repeat (3) step(1'b0, 1'b0, 1'b1);
        idle(5);

        // short press
        clear_counts();
        step(1'b1, 1'b0, 1'b0);
        idle(99);
        step(1'b0, 1'b1, 1'b0);
        rel = cyc;
        idle(L_DC + 200);
        check("short_count", n_short, 1);
        check("short_time", t_short - rel, L_DC);
        check("short_other", n_double + n_long + n_repeat, 0);

        // double click
        clear_counts();
        step(1'b1, 1'b0, 1'b0);
        idle(99);
        step(1'b0, 1'b1, 1'b0);
        idle(499);
        step(1'b1, 1'b0, 1'b0);
        idle(299);
        step(1'b0, 1'b1, 1'b0);
        rel = cyc;
        idle(L_DC + 100);
        check("double_count", n_double, 1);
        check("double_time", t_double, rel);
        check("double_noshort", n_short, 0);

        // long press with repeats
        clear_counts();
        step(1'b1, 1'b0, 1'b0);
        t0 = cyc;
        idle(8499);
        step(1'b0, 1'b1, 1'b0);
        idle(L_DC + 100);
        check("long_count", n_long, 1);
        check("long_time", t_long - t0, L_LONG);
        check("repeat_count", n_repeat, 3);
        check("repeat_last", t_repeat - t_long, 3 * L_REP);
        check("long_noshort", n_short, 0);
        check("long_busy_low", bus.busy, 1'b0);

        // second press exactly on the last gap cycle
        clear_counts();
        step(1'b1, 1'b0, 1'b0);
        idle(50);
        step(1'b0, 1'b1, 1'b0);
        idle(L_DC - 1);
        step(1'b1, 1'b0, 1'b0);
        idle(50);
        step(1'b0, 1'b1, 1'b0);
        idle(L_DC + 50);
        check("bnd_noshort", n_short, 0);
        check("bnd_double", n_double, 1);

        // reset during long hold
        step(1'b1, 1'b0, 1'b0);
        idle(L_LONG + 1500);
        step(1'b0, 1'b0, 1'b1);
        clear_counts();
        check("rst_busy", bus.busy, 1'b0);
        idle(5);
        step(1'b0, 1'b1, 1'b0);
        idle(L_DC + 200);
        check("rst_no_pulse", n_short + n_double + n_long + n_repeat, 0);

        // stray events while idle
        clear_counts();
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        idle(100);
        check("stray_no_pulse", n_short + n_double + n_long + n_repeat, 0);
        check("stray_busy", bus.busy, 1'b0);

        // random activity
        for (int i = 0; i < 25; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: step(1'b1, 1'b0, 1'b0);
                4, 5, 6, 7: step(1'b0, 1'b1, 1'b0);
                8:          step(1'b1, 1'b1, 1'b0);
                default:    step(1'b0, 1'b0, 1'b1);
            endcase
            idle(pick_gap());
        end
        step(1'b0, 1'b1, 1'b0);
        idle(L_DC + 10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
